// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver recovering 8N1 frames from an asynchronous pin.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking instead.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_d;
    logic          perr_q, perr_d;
`endif
    logic          tick;

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // The counter reloads a full bit period on every expiry, so each timed
    // state only has to act on tick; IDLE preloads the half-bit delay.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? BIT_M1 : cnt_q - CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = HALF_M1;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_d   = 3'd0;
                    state_d = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_err_d = (^shift_q) ^ rx_s_q;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = rx_s_q ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A low stop bit outranks a parity mismatch, so at most one pulse fires.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (state_q == STOP && tick) begin
            if (!rx_s_q) begin
                ferr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_err_q) begin
                perr_d = 1'b1;
            end
`endif
            else begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end
        end
    end

    assign uart_rx_data  = data_q;
    assign uart_rx_valid = valid_q;
    assign frame_err     = ferr_q;
    assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err    = perr_q;
`else
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frame vectors plus hand-written glitch, framing-error
// and reset-mid-frame sequences for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int LAT   = 2 + HALF + 9 * CPB + 1 + (NBITS - 10) * CPB;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       badPar;
        int         gapAfter;
        logic       expValid;
        logic       expFerr;
        logic       expPerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         cyc = 0;
    int         validCyc[$];
    logic [7:0] validData[$];
    int         ferrCyc[$];
    int         perrCyc[$];
    int         exclViol = 0;
    int         nPass = 0;
    int         nChecks = 0;
    vec_t       vecs[$];
    logic [7:0] lastGood;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (uart_rx_valid === 1'b1) begin
            validCyc.push_back(cyc);
            validData.push_back(uart_rx_data);
        end
        if (frame_err === 1'b1) ferrCyc.push_back(cyc);
        if (parity_err === 1'b1) perrCyc.push_back(cyc);
        if (int'(uart_rx_valid === 1'b1) + int'(frame_err === 1'b1) + int'(parity_err === 1'b1) > 1)
            exclViol++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearMonitor();
        validCyc.delete();
        validData.delete();
        ferrCyc.delete();
        perrCyc.delete();
    endtask

    // Drives one frame starting at a falling clock edge; the line is left at the stop-bit level.
    task automatic applyStimulus(input vec_t v, output int startCyc);
        startCyc = cyc;
        rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = v.data[i];
            waitCycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^v.data) ^ v.badPar;
        waitCycles(CPB);
`endif
        rx = v.stopBit;
        waitCycles(CPB);
    endtask

    function automatic vec_t mkVec(input logic [7:0] d, input logic stopBit, input logic badPar,
                                   input int gap, input logic eV, input logic eF, input logic eP);
        vec_t v;
        v.data = d; v.stopBit = stopBit; v.badPar = badPar; v.gapAfter = gap;
        v.expValid = eV; v.expFerr = eF; v.expPerr = eP;
        return v;
    endfunction

    initial begin
        int c;
        int prevValid;
        int prevGap;
        vec_t v;

        rst_n = 1'b1;
        rx    = 1'b1;
        #1 rst_n = 1'b0;
        waitCycles(3);
        checkOutput("reset valid", uart_rx_valid, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset parity_err", parity_err, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset data", uart_rx_data, 8'h00);
        rst_n = 1'b1;
        waitCycles(5);
        lastGood = 8'h00;

        vecs.push_back(mkVec(8'h41, 1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'h41, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'h42, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'h70, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'h71, 1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'h00, 1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'hFF, 1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'hC3, 1'b0, 1'b0, 20, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkVec(8'h96, 1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0));
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mkVec(8'h07, 1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(8'h07, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b1));
`endif

        prevValid = -1;
        prevGap   = -1;
        for (int i = 0; i < vecs.size(); i++) begin
            clearMonitor();
            applyStimulus(vecs[i], c);
            checkOutput($sformatf("v%0d valid count", i), validCyc.size(), 32'(vecs[i].expValid));
            checkOutput($sformatf("v%0d frame_err count", i), ferrCyc.size(), 32'(vecs[i].expFerr));
            checkOutput($sformatf("v%0d parity_err count", i), perrCyc.size(), 32'(vecs[i].expPerr));
            if (vecs[i].expValid && validCyc.size() > 0) begin
                lastGood = vecs[i].data;
                checkOutput($sformatf("v%0d valid latency", i), validCyc[0] - c, LAT);
                checkOutput($sformatf("v%0d pulse data", i), validData[0], vecs[i].data);
                if (prevGap == 0 && prevValid >= 0)
                    checkOutput($sformatf("v%0d back-to-back spacing", i), validCyc[0] - prevValid, FRAME);
                prevValid = validCyc[0];
            end
            if (vecs[i].expFerr && ferrCyc.size() > 0)
                checkOutput($sformatf("v%0d frame_err latency", i), ferrCyc[0] - c, LAT);
            if (vecs[i].expPerr && perrCyc.size() > 0)
                checkOutput($sformatf("v%0d parity_err latency", i), perrCyc[0] - c, LAT);
            checkOutput($sformatf("v%0d held data", i), uart_rx_data, lastGood);
            prevGap = vecs[i].gapAfter;
            rx = 1'b1;
            waitCycles(vecs[i].gapAfter);
        end

        // Start-bit glitch of four cycles must be rejected silently.
        waitCycles(10);
        clearMonitor();
        rx = 1'b0;
        waitCycles(4);
        checkOutput("glitch busy high", busy, 1);
        rx = 1'b1;
        waitCycles(10);
        checkOutput("glitch busy released", busy, 0);
        checkOutput("glitch pulses", validCyc.size() + ferrCyc.size() + perrCyc.size(), 0);
        applyStimulus(mkVec(8'h55, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), c);
        checkOutput("after glitch valid count", validCyc.size(), 1);
        checkOutput("after glitch data", uart_rx_data, 8'h55);
        lastGood = 8'h55;
        waitCycles(10);

        // Framing error followed by a long break.
        clearMonitor();
        applyStimulus(mkVec(8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0), c);
        waitCycles(100);
        checkOutput("break frame_err count", ferrCyc.size(), 1);
        if (ferrCyc.size() > 0) checkOutput("break frame_err latency", ferrCyc[0] - c, LAT);
        checkOutput("break valid count", validCyc.size(), 0);
        checkOutput("break data held", uart_rx_data, lastGood);
        checkOutput("break busy held", busy, 1);
        rx = 1'b1;
        waitCycles(4);
        checkOutput("break busy released", busy, 0);
        clearMonitor();
        applyStimulus(mkVec(8'h3C, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), c);
        checkOutput("after break valid count", validCyc.size(), 1);
        checkOutput("after break data", uart_rx_data, 8'h3C);
        waitCycles(10);

        // Reset asserted during data bit 3 of 0xFF.
        clearMonitor();
        rx = 1'b0;
        waitCycles(CPB);
        rx = 1'b1;
        waitCycles(3 * CPB + 8);
        checkOutput("mid-frame busy before reset", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-frame reset valid", uart_rx_valid, 0);
        checkOutput("mid-frame reset frame_err", frame_err, 0);
        checkOutput("mid-frame reset busy", busy, 0);
        checkOutput("mid-frame reset data", uart_rx_data, 8'h00);
        waitCycles(CPB - 8 + 5 * CPB);
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("mid-frame no pulses", validCyc.size() + ferrCyc.size() + perrCyc.size(), 0);
        checkOutput("mid-frame idle after release", busy, 0);
        applyStimulus(mkVec(8'h12, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), c);
        checkOutput("after reset valid count", validCyc.size(), 1);
        if (validCyc.size() > 0) checkOutput("after reset latency", validCyc[0] - c, LAT);
        checkOutput("after reset data", uart_rx_data, 8'h12);
        waitCycles(10);

        checkOutput("pulse exclusivity violations", exclViol, 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
